// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM encoding,
// default parameters and the counter-width helper.
package btn_debounce_pkg;

    localparam int unsigned DefaultNBtn           = 3;
    // 10 ms of stable input at a 12 MHz system clock.
    localparam int unsigned DefaultDebounceCycles = 120000;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPressCnt = 2'd1,
        StHeld     = 2'd2,
        StRelCnt   = 2'd3
    } dbnc_state_e;

    // Counter only has to reach cycles-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button / event-status bundle between the debouncer and the polling core.
interface btn_debounce_if
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_BTN = DefaultNBtn
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic             evt_read;
    logic [N_BTN-1:0] evt_status;

    // Core / board side.
    modport master (
        output btn_raw,
        output evt_read,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  evt_status
    );

    // Debouncer side.
    modport slave (
        input  btn_raw,
        input  evt_read,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output evt_status
    );

endinterface

// File: rtl/btn_debounce_channel.sv
// One debounced button: 2-flop synchronizer, press/release counting FSM,
// registered level and one-cycle press/release strobes.
module btn_debounce_channel
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned    CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    dbnc_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
        end
    end

    // FSM, counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Next state: each count state exits at CntMax, so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s2_q) begin
                    state_d = StPressCnt;
                    cnt_d   = '0;
                end
            end
            StPressCnt: begin
                if (!s2_q) begin
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StHeld;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                if (!s2_q) begin
                    state_d = StRelCnt;
                    cnt_d   = '0;
                end
            end
            StRelCnt: begin
                if (s2_q) begin
                    state_d = StHeld;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        level_d = (state_d == StHeld) || (state_d == StRelCnt);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-button debouncer: N_BTN independent channels plus sticky press flags
// that the core polls and clears with evt_read.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_BTN           = DefaultNBtn,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic          CLK,
    input  logic          RST_N,
    btn_debounce_if.slave bus
);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] evt_q, evt_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i    (CLK),
            .rst_ni   (RST_N),
            .btn_i    (bus.btn_raw[i]),
            .level_o  (level[i]),
            .press_o  (press[i]),
            .release_o(rel[i])
        );
    end

    // Sticky flags: a press in the same cycle as a read keeps its flag set.
    always_comb begin
        evt_d = (evt_q & ~{N_BTN{bus.evt_read}}) | press;
    end

    // Event status register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign bus.btn_level     = level;
    assign bus.press_pulse   = press;
    assign bus.release_pulse = rel;
    assign bus.evt_status    = evt_q;

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 3, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 120000, stable-input cycles required to accept a change (10 ms at 12 MHz); legal range 2..2^20.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port btn_raw  input  N_BTN  asynchronous raw button levels, active-high (board BTN1..BTN3).
REQ-006 SHALL have port btn_level  output  N_BTN  debounced level, 1 = pressed.
REQ-007 SHALL have port press_pulse  output  N_BTN  one-cycle strobe per accepted press.
REQ-008 SHALL have port release_pulse  output  N_BTN  one-cycle strobe per accepted release.
REQ-009 SHALL have port evt_read  input  1  read strobe from the core; clears evt_status.
REQ-010 SHALL have port evt_status  output  N_BTN  sticky per-button press flags, for the core to poll.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 Each channel SHALL run a 4-state FSM: IDLE, PRESS_CNT, HELD, REL_CNT, with a counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-013 IDLE: s2=1 -> PRESS_CNT, counter cleared to 0; else stay.
REQ-014 PRESS_CNT: s2=0 -> IDLE (glitch rejected, no pulse); counter == DEBOUNCE_CYCLES-1 -> HELD, press_pulse=1 for one cycle; else counter+1.
REQ-015 HELD: s2=0 -> REL_CNT, counter cleared to 0; else stay.
REQ-016 REL_CNT: s2=1 -> HELD (no pulse); counter == DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1 for one cycle; else counter+1.
REQ-017 btn_level SHALL be 1 exactly in HELD and REL_CNT; all outputs SHALL be registered.
REQ-018 Latency: with the edge that first samples btn_raw high counted as edge 0 and input stable thereafter, press_pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2; btn_level rises in the same cycle; release timing is symmetric.
REQ-019 Any input pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no strobe and no btn_level change.
REQ-020 evt_status[i] SHALL set on press_pulse[i] and clear on evt_read; when both occur in the same cycle, set wins and the flag stays 1.
REQ-021 evt_read while no flag is set SHALL have no effect; evt_read SHALL not affect FSMs, btn_level or the strobes.
REQ-022 Channels SHALL be fully independent; simultaneous presses on several buttons SHALL produce simultaneous strobes.
REQ-023 The counter SHALL never wrap: it saturates logically because each count state exits at DEBOUNCE_CYCLES-1.

Reset
REQ-024 RST_N low SHALL immediately force every FSM to IDLE, and clear counters, synchronizer flops, btn_level, press_pulse, release_pulse and evt_status to 0.
REQ-025 Reset asserted mid-count or in HELD SHALL emit no release_pulse; after release, a button still held SHALL be re-accepted through a full press debounce.
REQ-026 Reset deassertion SHALL be synchronized externally; the block needs no deassertion synchronizer.

Structure
REQ-027 The FSM state encoding and the default DEBOUNCE_CYCLES constant SHALL live in the shared board package.
REQ-028 Each channel (synchronizer, FSM, counter, strobes) SHALL be one sub-module, debounce_channel, instantiated N_BTN times; evt_status logic stays in the top level.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-029 btn_raw[0] 0->1 held -> press_pulse[0] high for exactly one cycle after edge 6; btn_level[0]=1 from then; evt_status=3'b001.
REQ-030 btn_raw[1] high for 3 cycles then low -> no press_pulse; btn_level[1] stays 0; evt_status[1] stays 0.
REQ-031 Button 0 held, then low for 2 cycles, then high again -> no release_pulse; btn_level[0] stays 1.
REQ-032 press_pulse[2] and evt_read in the same cycle -> evt_status[2]=1; next lone evt_read -> evt_status=0.
REQ-033 RST_N pulsed low while button 0 is in HELD -> all outputs 0 at once, no release_pulse; button still high -> new press_pulse 7 cycles after RST_N rises.
REQ-034 Default parameters, all 3 buttons pressed together with 5 ms bounce then stable -> one simultaneous press_pulse=3'b111, 120002 cycles after the last bounce edge.
